alu_share_arbiter: RTL

Two-requester sequencer for the shared N-bit four-function ALU: arbitrates between requesters, latches the winning operands, executes one operation and holds the registered result until acknowledged. Sits between the lab's requester blocks and the ALU datapath so that only one request occupies the ALU at a time. The ALU function is computed internally from registered operands.

---
 rtl/alu_share_if.sv | 28 ++
 rtl/alu_share_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/alu_share_if.sv
// Handshake and operand bundle between two requesters and the shared ALU sequencer.
// master = requester/testbench side, slave = alu_share_arbiter side.
interface alu_share_if #(parameter int N = 4);
  logic           req0;
  logic           req1;
  logic [N-1:0]   a0;
  logic [N-1:0]   b0;
  logic [N-1:0]   a1;
  logic [N-1:0]   b1;
  logic [1:0]     func0;
  logic [1:0]     func1;
  logic           ack;
  logic           gnt0;
  logic           gnt1;
  logic           done;
  logic           owner;
  logic [2*N-1:0] aluout;

  modport master (
    output req0, req1, a0, b0, a1, b1, func0, func1, ack,
    input  gnt0, gnt1, done, owner, aluout
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, func0, func1, ack,
    output gnt0, gnt1, done, owner, aluout
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester sequencer for the shared four-function ALU: arbitrate, latch, execute, hold until Ack.
// Define ALU_SHARE_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
  parameter int N = 4
) (
  input logic        clk,
  input logic        rst,
  alu_share_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [1:0]     r_func;
  logic           r_idx;
  logic           r_last;
  logic           r_gnt0;
  logic           r_gnt1;
  logic           r_done;
  logic           r_owner;
  logic [2*N-1:0] r_aluout;

  logic           w_anyReq;
  logic           w_zeroWinsTie;
  logic           w_sel;
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_result;

  assign w_anyReq = bus.req0 | bus.req1;

  // Requester 0 takes a tie when this is high; fixed priority keeps Last but forces the tie to 0.
`ifdef ALU_SHARE_RR_EN
  assign w_zeroWinsTie = r_last;
`else
  assign w_zeroWinsTie = r_last | 1'b1;
`endif

  assign w_sel = bus.req1 & ~(bus.req0 & w_zeroWinsTie);

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_result = '0;
    case (r_func)
      2'b00:   w_result[N:0] = w_sum;
      2'b01:   w_result[0]   = |{r_a, r_b};
      2'b10:   w_result[0]   = &{r_a, r_b};
      default: w_result      = {r_a, r_b};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_func   <= 2'b00;
      r_idx    <= 1'b0;
      r_last   <= 1'b1;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done   <= 1'b0;
      r_owner  <= 1'b0;
      r_aluout <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_a     <= w_sel ? bus.a1    : bus.a0;
            r_b     <= w_sel ? bus.b1    : bus.b0;
            r_func  <= w_sel ? bus.func1 : bus.func0;
            r_idx   <= w_sel;
            r_last  <= w_sel;
            r_gnt0  <= ~w_sel;
            r_gnt1  <= w_sel;
            r_state <= EXEC;
          end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
          end
        end
        EXEC: begin
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_aluout <= w_result;
          r_owner  <= r_idx;
          r_done   <= 1'b1;
          r_state  <= HOLD;
        end
        HOLD: begin
          if (bus.ack) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0   = r_gnt0;
  assign bus.gnt1   = r_gnt1;
  assign bus.done   = r_done;
  assign bus.owner  = r_owner;
  assign bus.aluout = r_aluout;

endmodule
